// File: rtl/vga_plot_engine.sv
// Command-driven pixel writer for the VGA adapter plot port.
// Commands queue in a small FIFO and are rasterised row-major at one pixel per clock.
module vga_plot_engine #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3,
    parameter int XMAX  = 159,
    parameter int YMAX  = 119,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMDW = 2 + 2*XW + 2*YW + CW;

    localparam logic [1:0]    OP_PIXEL = 2'b00;
    localparam logic [1:0]    OP_FILL  = 2'b01;
    localparam logic [1:0]    OP_CLEAR = 2'b10;
    localparam logic [XW-1:0] XMAX_X   = XW'(XMAX);
    localparam logic [YW-1:0] YMAX_Y   = YW'(YMAX);
    localparam logic [XW:0]   XMAX_W   = (XW+1)'(XMAX);
    localparam logic [YW:0]   YMAX_W   = (YW+1)'(YMAX);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

    // ---------------- command FIFO ----------------
    logic [CMDW-1:0] fifo_mem [DEPTH];
    logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
    logic            fifo_empty, fifo_full, push, pop;

    logic [1:0]    head_op;
    logic [XW-1:0] head_x0, head_w;
    logic [YW-1:0] head_y0, head_h;
    logic [CW-1:0] head_col;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign {head_op, head_x0, head_y0, head_w, head_h, head_col} = fifo_mem[rd_ptr_reg[AW-1:0]];

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_colour};
        end
    end

    // ---------------- working registers ----------------
    state_t        state_reg, state_next;
    logic [1:0]    op_reg, op_next;
    logic [XW-1:0] x0_reg, x0_next, w_reg, w_next, xe_reg, xe_next, cx_reg, cx_next;
    logic [YW-1:0] y0_reg, y0_next, h_reg, h_next, ye_reg, ye_next, cy_reg, cy_next;
    logic [CW-1:0] col_reg, col_next;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic [CW-1:0] colour_reg, colour_next;
    logic          plot_reg, plot_next, done_reg, done_next;

    // ---------------- command normalisation (used in LOAD) ----------------
    logic [XW-1:0] nx0, nw, xe_clip;
    logic [YW-1:0] ny0, nh, ye_clip;
    logic [XW:0]   x_end_wide;
    logic [YW:0]   y_end_wide;
    logic          empty_cmd;

    always_comb begin
        nx0 = x0_reg;
        ny0 = y0_reg;
        nw  = w_reg;
        nh  = h_reg;
        case (op_reg)
            OP_PIXEL: begin
                nw = XW'(1);
                nh = YW'(1);
            end
            OP_FILL: ;
            OP_CLEAR: begin
                nx0 = '0;
                ny0 = '0;
                nw  = XW'(XMAX + 1);
                nh  = YW'(YMAX + 1);
            end
            default: nw = '0;
        endcase
        // One extra bit keeps the far edge from wrapping before the clip.
        x_end_wide = {1'b0, nx0} + {1'b0, nw} - (XW+1)'(1);
        y_end_wide = {1'b0, ny0} + {1'b0, nh} - (YW+1)'(1);
        xe_clip    = (x_end_wide > XMAX_W) ? XMAX_X : x_end_wide[XW-1:0];
        ye_clip    = (y_end_wide > YMAX_W) ? YMAX_Y : y_end_wide[YW-1:0];
        empty_cmd  = (nw == '0) || (nh == '0) || (nx0 > XMAX_X) || (ny0 > YMAX_Y);
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        op_next     = op_reg;
        x0_next     = x0_reg;
        y0_next     = y0_reg;
        w_next      = w_reg;
        h_next      = h_reg;
        col_next    = col_reg;
        xe_next     = xe_reg;
        ye_next     = ye_reg;
        cx_next     = cx_reg;
        cy_next     = cy_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    op_next    = head_op;
                    x0_next    = head_x0;
                    y0_next    = head_y0;
                    w_next     = head_w;
                    h_next     = head_h;
                    col_next   = head_col;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (empty_cmd) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    x0_next     = nx0;
                    xe_next     = xe_clip;
                    ye_next     = ye_clip;
                    cx_next     = nx0;
                    cy_next     = ny0;
                    x_next      = nx0;
                    y_next      = ny0;
                    colour_next = col_reg;
                    plot_next   = 1'b1;
                    state_next  = DRAW;
                end
            end
            DRAW: begin
                // cx/cy name the pixel currently on the outputs.
                if (cx_reg == xe_reg) begin
                    if (cy_reg == ye_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cx_next   = x0_reg;
                        cy_next   = cy_reg + YW'(1);
                        x_next    = x0_reg;
                        y_next    = cy_reg + YW'(1);
                        plot_next = 1'b1;
                    end
                end else begin
                    cx_next   = cx_reg + XW'(1);
                    x_next    = cx_reg + XW'(1);
                    plot_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            op_reg     <= '0;
            x0_reg     <= '0;
            y0_reg     <= '0;
            w_reg      <= '0;
            h_reg      <= '0;
            col_reg    <= '0;
            xe_reg     <= '0;
            ye_reg     <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            op_reg     <= op_next;
            x0_reg     <= x0_next;
            y0_reg     <= y0_next;
            w_reg      <= w_next;
            h_reg      <= h_next;
            col_reg    <= col_next;
            xe_reg     <= xe_next;
            ye_reg     <= ye_next;
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            done_reg   <= done_next;
        end
    end

    assign x      = x_reg;
    assign y      = y_reg;
    assign colour = colour_reg;
    assign plot   = plot_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vga_plot_engine.sv
// Bench for vga_plot_engine: table vectors, hand-written timing sequences and
// random commands checked against a pixel-list model built from the raster rules.
module tb_vga_plot_engine;
    localparam int XW = 8, YW = 7, CW = 3;
    localparam int XMAXP = 159, YMAXP = 119;

    logic          clk, reset, cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] cmd_x0, cmd_w, x;
    logic [YW-1:0] cmd_y0, cmd_h, y;
    logic [CW-1:0] cmd_colour, colour;
    logic          plot, busy, done;

    int errors = 0, checks = 0;
    int plot_cnt = 0, done_cnt = 0;
    int exp_q[$];
    int act_q[$];

    vga_plot_engine dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_colour(cmd_colour), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (plot) plot_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] op;
        int x0, y0, w, h, col;
        int n, first, last;
    } vec_t;

    function automatic int pk(input int xx, input int yy, input int c);
        return (xx << 16) | (yy << 8) | c;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected pixel list straight from the command semantics.
    task automatic model(input logic [1:0] op, input int x0, input int y0,
                         input int w, input int h, input int col);
        exp_q.delete();
        if (op == 2'b00) begin
            w = 1; h = 1;
        end else if (op == 2'b10) begin
            x0 = 0; y0 = 0; w = XMAXP + 1; h = YMAXP + 1;
        end else if (op == 2'b11) begin
            w = 0;
        end
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                if (xx <= XMAXP && yy <= YMAXP) exp_q.push_back(pk(xx, yy, col));
    endtask

    task automatic scramble();
        cmd_op     = 2'($urandom);
        cmd_x0     = XW'($urandom);
        cmd_y0     = YW'($urandom);
        cmd_w      = XW'($urandom);
        cmd_h      = YW'($urandom);
        cmd_colour = CW'($urandom);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input int x0, input int y0,
                             input int w, input int h, input int col);
        cmd_op     = op;
        cmd_x0     = XW'(x0);
        cmd_y0     = YW'(y0);
        cmd_w      = XW'(w);
        cmd_h      = YW'(h);
        cmd_colour = CW'(col);
        cmd_valid  = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy === 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    // Returns at the negedge following the accepting edge E0.
    task automatic issue(input logic [1:0] op, input int x0, input int y0,
                         input int w, input int h, input int col);
        @(negedge clk);
        drive_cmd(op, x0, y0, w, h, col);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic collect(input int bound, output int done_at, output int first_at,
                           output int last_at);
        act_q.delete();
        done_at = -1; first_at = -1; last_at = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (plot) begin
                act_q.push_back(pk(int'(x), int'(y), int'(colour)));
                if (first_at < 0) first_at = c;
                last_at = c;
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [1:0] op, input int x0,
                                 input int y0, input int w, input int h, input int col,
                                 input int bound);
        int done_at, first_at, last_at, bad, n, m;
        model(op, x0, y0, w, h, col);
        n = exp_q.size();
        wait_idle(300);
        issue(op, x0, y0, w, h, col);
        collect(bound, done_at, first_at, last_at);
        m = (act_q.size() < n) ? act_q.size() : n;
        bad = (act_q.size() > n) ? act_q.size() - n : n - act_q.size();
        for (int i = 0; i < m; i++) if (act_q[i] != exp_q[i]) bad++;
        chk({name, " pixel_mismatches"}, bad, 0);
        chk({name, " done_cycle"}, done_at, n + 2);
        if (n > 0) begin
            chk({name, " first_plot_cycle"}, first_at, 2);
            chk({name, " plot_span"}, last_at - first_at + 1, n);
        end
        @(negedge clk);
        chk({name, " done_pulse_end"}, int'({done, plot}), 0);
    endtask

    vec_t tbl[10];

    initial begin
        int done_at, first_at, last_at, waited, d_at_accept, act;
        logic [5:0] tp, td;
        int px1, px2, base_p, base_d;
        logic [1:0] rop;

        tbl[0] = '{2'b00, 10,  20,  0, 0, 5, 1, pk(10, 20, 5),   pk(10, 20, 5)};
        tbl[1] = '{2'b01, 158, 118, 4, 3, 3, 4, pk(158, 118, 3), pk(159, 119, 3)};
        tbl[2] = '{2'b01, 5,   5,   0, 3, 1, 0, 0, 0};
        tbl[3] = '{2'b01, 0,   0,   3, 2, 7, 6, pk(0, 0, 7),     pk(2, 1, 7)};
        tbl[4] = '{2'b11, 4,   4,   5, 5, 2, 0, 0, 0};
        tbl[5] = '{2'b01, 160, 10,  2, 2, 4, 0, 0, 0};
        tbl[6] = '{2'b01, 10,  119, 3, 5, 2, 3, pk(10, 119, 2),  pk(12, 119, 2)};
        tbl[7] = '{2'b00, 159, 119, 9, 9, 6, 1, pk(159, 119, 6), pk(159, 119, 6)};
        tbl[8] = '{2'b00, 200, 3,   0, 0, 1, 0, 0, 0};
        tbl[9] = '{2'b01, 20,  20,  4, 0, 3, 0, 0, 0};

        // Reset with garbage on the inputs.
        reset = 1'b0;
        cmd_valid = 1'b0;
        scramble();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom);
            scramble();
            #1;
            chk("reset plot_done_busy_ready", int'({plot, done, busy, cmd_ready}), 1);
            chk("reset xyc", pk(int'(x), int'(y), int'(colour)), 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset plot_done_busy_ready", int'({plot, done, busy, cmd_ready}), 1);
            chk("post_reset xyc", pk(int'(x), int'(y), int'(colour)), 0);
        end

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].x0, tbl[i].y0,
                          tbl[i].w, tbl[i].h, tbl[i].col, 300);
            chk($sformatf("vec%0d plot_count", i), act_q.size(), tbl[i].n);
            if (tbl[i].n > 0) begin
                chk($sformatf("vec%0d first_pixel", i), act_q[0], tbl[i].first);
                chk($sformatf("vec%0d last_pixel", i), act_q[act_q.size()-1], tbl[i].last);
            end
            $display("vec%0d op=%0d x0=%0d y0=%0d w=%0d h=%0d plots=%0d", i, tbl[i].op,
                     tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, act_q.size());
        end

        // Back-to-back pixels: two idle cycles between plots, done on the first of them.
        wait_idle(300);
        @(negedge clk);
        drive_cmd(2'b00, 30, 40, 0, 0, 6);
        @(posedge clk);
        @(negedge clk);
        drive_cmd(2'b00, 31, 41, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        px1 = 0; px2 = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            tp[k-1] = plot;
            td[k-1] = done;
            if (k == 2) px1 = pk(int'(x), int'(y), int'(colour));
            if (k == 5) px2 = pk(int'(x), int'(y), int'(colour));
        end
        chk("b2b plot_trace", int'(tp), 6'b010010);
        chk("b2b done_trace", int'(td), 6'b100100);
        chk("b2b pixel1", px1, pk(30, 40, 6));
        chk("b2b pixel2", px2, pk(31, 41, 1));
        $display("b2b plot_trace=%b done_trace=%b", tp, td);

        // Backpressure: a 3x2 primer keeps the engine drawing while the FIFO fills.
        wait_idle(300);
        #1;
        base_p = plot_cnt;
        base_d = done_cnt;
        @(negedge clk);
        drive_cmd(2'b01, 20, 30, 3, 2, 1);
        @(posedge clk);
        waited = 0;
        d_at_accept = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) chk("fifo full after 4th ready", int'(cmd_ready), 0);
            drive_cmd(2'b01, 40 + 10 * i, 40, 3, 2, i + 2);
            while (!cmd_ready && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (i == 4) begin
                #1;
                d_at_accept = done_cnt - base_d;
            end
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("5th held while full", int'(waited > 0), 1);
        chk("5th accepted after first done", d_at_accept, 1);
        wait_idle(300);
        #1;
        chk("backpressure plot cycles", plot_cnt - base_p, 36);
        chk("backpressure done pulses", done_cnt - base_d, 6);
        $display("backpressure waited=%0d plots=%0d dones=%0d", waited,
                 plot_cnt - base_p, done_cnt - base_d);

        // Random commands.
        for (int i = 0; i < 40; i++) begin
            act = $urandom_range(0, 9);
            rop = (act < 3) ? 2'b00 : (act < 8) ? 2'b01 : 2'b11;
            run_and_check($sformatf("rnd%0d", i), rop, $urandom_range(0, 175),
                          $urandom_range(0, 127), $urandom_range(0, 12),
                          $urandom_range(0, 8), $urandom_range(0, 7), 300);
            $display("rnd%0d op=%0d plots=%0d expected=%0d", i, rop, act_q.size(), exp_q.size());
        end

        // Full clear.
        run_and_check("clear", 2'b10, 7, 7, 3, 3, 0, 19400);
        $display("clear plots=%0d", act_q.size());

        // Reset during a clear with two commands queued.
        wait_idle(300);
        issue(2'b10, 0, 0, 0, 0, 4);
        drive_cmd(2'b01, 1, 1, 5, 5, 2);
        @(posedge clk);
        @(negedge clk);
        drive_cmd(2'b01, 2, 2, 5, 5, 3);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_clear plotting", int'(plot), 1);
        reset = 1'b0;
        #1;
        chk("abort plot_done_busy_ready", int'({plot, done, busy, cmd_ready}), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (plot || done) act++;
        end
        chk("post_abort activity", act, 0);
        chk("post_abort busy", int'(busy), 0);
        $display("abort post-release activity=%0d busy=%0d", act, busy);
        run_and_check("after_abort", 2'b00, 3, 4, 0, 0, 7, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
